// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR lane logic: key FSM states, judgement
// event codes and a saturating signed add.
package ddr_pkg;

  typedef enum logic [1:0] {
    KEY_UP    = 2'd0,
    KEY_JUDGE = 2'd1,
    KEY_HELD  = 2'd2
  } key_state_e;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_HIT   = 3'd1,
    EV_EARLY = 3'd2,
    EV_MISS  = 3'd3,
    EV_WRONG = 3'd4
  } event_e;

  // Adds two signed values and clamps the result to a w-bit two's complement range.
  function automatic int sat_add(input int a, input int b, input int w);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/lane_key_fsm.sv
// Key press edge detector: samples the lane key and emits a single-cycle judge
// pulse per press, however long the key is held.
import ddr_pkg::*;

module lane_key_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic key,
  output logic judge
);

  localparam logic [1:0] UP    = KEY_UP;
  localparam logic [1:0] JUDGE = KEY_JUDGE;
  localparam logic [1:0] HELD  = KEY_HELD;

  logic       key_reg;
  logic [1:0] state_reg;
  logic [1:0] state_next;

  // JUDGE always finishes its transition, even with the game paused.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      UP:      if (key_reg && en) state_next = JUDGE;
      JUDGE:   state_next = key_reg ? HELD : UP;
      HELD:    if (!key_reg && en) state_next = UP;
      default: state_next = UP;
    endcase
    if (clr) state_next = UP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg   <= 1'b0;
      state_reg <= UP;
    end else begin
      key_reg   <= key;
      state_reg <= state_next;
    end
  end

  assign judge = (state_reg == JUDGE);

endmodule

// File: rtl/lane_column.sv
// One DDR arrow lane: light shift register, press judge against the top two
// cells, per-cycle signed point delta, saturating score and combo counter.
import ddr_pkg::*;

module lane_column #(
  parameter int DEPTH     = 5,
  parameter int PT_W      = 4,
  parameter int SCORE_W   = 10,
  parameter int COMBO_W   = 6,
  parameter int HIT_PTS   = 2,
  parameter int EARLY_PTS = 1,
  parameter int MISS_PTS  = 2,
  parameter int WRONG_PTS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      step,
  input  logic                      spawn,
  input  logic                      key,
  output logic [DEPTH-1:0]          lighton,
  output logic signed [PT_W-1:0]    pt,
  output logic                      pt_valid,
  output logic signed [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0]        combo
);

  logic                      judge;
  logic                      judge_act;
  logic                      step_act;
  logic                      miss;
  logic                      evt_valid;
  event_e                    judge_evt;
  int                        delta;
  logic [DEPTH-1:0]          light_reg;
  logic [DEPTH-1:0]          cleared;
  logic [DEPTH-1:0]          shifted;
  logic [DEPTH-1:0]          light_next;
  logic signed [PT_W-1:0]    pt_reg;
  logic                      pt_valid_reg;
  logic signed [SCORE_W-1:0] score_reg;
  logic signed [SCORE_W-1:0] score_next;
  logic [COMBO_W-1:0]        combo_reg;
  logic [COMBO_W-1:0]        combo_next;

  lane_key_fsm u_key_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .key   (key),
    .judge (judge)
  );

  assign judge_act = judge && en && !clr;
  assign step_act  = step && en && !clr;

  // Judgement looks at the pre-shift lights; its clear feeds the shift below.
  always_comb begin
    judge_evt = EV_NONE;
    cleared   = light_reg;
    if (judge_act) begin
      if (light_reg[DEPTH-1]) begin
        judge_evt          = EV_HIT;
        cleared[DEPTH-1]   = 1'b0;
      end else if (light_reg[DEPTH-2]) begin
        judge_evt          = EV_EARLY;
        cleared[DEPTH-2]   = 1'b0;
      end else begin
        judge_evt          = EV_WRONG;
      end
    end
  end

  assign shifted[0] = spawn;
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign shifted[gi] = cleared[gi-1];
    end
  endgenerate

  assign miss       = step_act && cleared[DEPTH-1];
  assign light_next = step_act ? shifted : cleared;
  assign evt_valid  = (judge_evt != EV_NONE) || miss;

  always_comb begin
    delta = 0;
    case (judge_evt)
      EV_HIT:   delta = HIT_PTS;
      EV_EARLY: delta = EARLY_PTS;
      EV_WRONG: delta = -WRONG_PTS;
      default:  delta = 0;
    endcase
    if (miss) delta = delta - MISS_PTS;
  end

  assign score_next = SCORE_W'(sat_add(int'(score_reg), delta, SCORE_W));

  // A penalty anywhere in the cycle wins over a hit's increment.
  always_comb begin
    combo_next = combo_reg;
    if (miss || judge_evt == EV_WRONG) begin
      combo_next = '0;
    end else if ((judge_evt == EV_HIT || judge_evt == EV_EARLY) && combo_reg != '1) begin
      combo_next = combo_reg + COMBO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_reg    <= '0;
      pt_reg       <= '0;
      pt_valid_reg <= 1'b0;
      score_reg    <= '0;
      combo_reg    <= '0;
    end else if (clr) begin
      light_reg    <= '0;
      pt_reg       <= '0;
      pt_valid_reg <= 1'b0;
      score_reg    <= '0;
      combo_reg    <= '0;
    end else begin
      light_reg    <= light_next;
      pt_reg       <= evt_valid ? PT_W'(delta) : '0;
      pt_valid_reg <= evt_valid;
      score_reg    <= score_next;
      combo_reg    <= combo_next;
    end
  end

  assign lighton  = light_reg;
  assign pt       = pt_reg;
  assign pt_valid = pt_valid_reg;
  assign score    = score_reg;
  assign combo    = combo_reg;

endmodule

// File: tb/tb_lane_column.sv
// Directed bench for lane_column (default parameters): expected outputs are
// queued as stimulus is driven and compared when the DUT should show them.
module tb_lane_column;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic              step = 1'b0;
  logic              spawn = 1'b0;
  logic              key = 1'b0;
  logic [4:0]        lighton;
  logic signed [3:0] pt;
  logic              pt_valid;
  logic signed [9:0] score;
  logic [5:0]        combo;

  lane_column dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .step     (step),
    .spawn    (spawn),
    .key      (key),
    .lighton  (lighton),
    .pt       (pt),
    .pt_valid (pt_valid),
    .score    (score),
    .combo    (combo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic [4:0]        light;
    logic signed [3:0] pt;
    logic              pv;
    logic signed [9:0] score;
    logic [5:0]        combo;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] m_light = '0;
  int         m_score = 0;
  int         m_combo = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_score(input int d);
    m_score = m_score + d;
    if (m_score > 511) m_score = 511;
    if (m_score < -512) m_score = -512;
  endtask

  task automatic push_exp(input string tag, input int pt_v, input logic pv);
    exp_t e;
    e.tag   = tag;
    e.light = m_light;
    e.pt    = 4'(pt_v);
    e.pv    = pv;
    e.score = 10'(m_score);
    e.combo = 6'(m_combo);
    exp_q.push_back(e);
  endtask

  task automatic check_out;
    exp_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    assert (lighton === e.light) else begin
      miscompares++;
      $error("FAIL %s lighton got %b want %b", e.tag, lighton, e.light);
    end
    assert (pt === e.pt) else begin
      miscompares++;
      $error("FAIL %s pt got %0d want %0d", e.tag, pt, e.pt);
    end
    assert (pt_valid === e.pv) else begin
      miscompares++;
      $error("FAIL %s pt_valid got %b want %b", e.tag, pt_valid, e.pv);
    end
    assert (score === e.score) else begin
      miscompares++;
      $error("FAIL %s score got %0d want %0d", e.tag, score, e.score);
    end
    assert (combo === e.combo) else begin
      miscompares++;
      $error("FAIL %s combo got %0d want %0d", e.tag, combo, e.combo);
    end
    $display("vector %0d %s: lighton=%b pt=%0d pv=%b score=%0d combo=%0d",
             vectors, e.tag, lighton, pt, pt_valid, score, combo);
  endtask

  task automatic do_step(input logic s, input bit chk, input string tag);
    bit missed;
    missed  = m_light[4];
    m_light = {m_light[3:0], s};
    if (missed) begin
      add_score(-2);
      m_combo = 0;
    end
    if (chk) push_exp(tag, missed ? -2 : 0, missed);
    step  = 1'b1;
    spawn = s;
    tick();
    step  = 1'b0;
    spawn = 1'b0;
    if (chk) check_out();
  endtask

  task automatic load_top;
    do_step(1'b1, 1'b0, "");
    repeat (4) do_step(1'b0, 1'b0, "");
  endtask

  // Model one judgement (and optionally a coinciding Step) and queue the result.
  task automatic model_press(input string tag, input bit with_step);
    int d;
    bit missed;
    d = 0;
    if (m_light[4]) begin
      m_light[4] = 1'b0;
      d = 2;
      if (m_combo < 63) m_combo++;
    end else if (m_light[3]) begin
      m_light[3] = 1'b0;
      d = 1;
      if (m_combo < 63) m_combo++;
    end else begin
      d = -1;
      m_combo = 0;
    end
    if (with_step) begin
      missed  = m_light[4];
      m_light = {m_light[3:0], 1'b0};
      if (missed) begin
        d = d - 2;
        m_combo = 0;
      end
    end
    add_score(d);
    push_exp(tag, d, 1'b1);
  endtask

  task automatic press(input string tag, input bit with_step);
    model_press(tag, with_step);
    key = 1'b1;
    tick();
    key = 1'b0;
    tick();
    if (with_step) step = 1'b1;
    tick();
    step = 1'b0;
    check_out();
    push_exp({tag, "_after"}, 0, 1'b0);
    tick();
    check_out();
  endtask

  initial begin
    int pulses;

    // Reset values
    repeat (2) tick();
    push_exp("reset", 0, 1'b0);
    check_out();
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Walk a note up the lane and off the top
    do_step(1'b1, 1'b1, "walk0");
    do_step(1'b0, 1'b1, "walk1");
    do_step(1'b0, 1'b1, "walk2");
    do_step(1'b0, 1'b1, "walk3");
    do_step(1'b0, 1'b1, "walk4");
    do_step(1'b0, 1'b1, "miss");

    // Hit, early hit, wrong press
    load_top();
    press("hit", 1'b0);
    do_step(1'b1, 1'b0, "");
    repeat (3) do_step(1'b0, 1'b0, "");
    press("early", 1'b0);
    press("wrong", 1'b0);

    // Held key: one judgement only
    load_top();
    model_press("held", 1'b0);
    pulses = 0;
    key = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pt_valid) pulses++;
      if (i == 2) check_out();
    end
    key = 1'b0;
    repeat (2) tick();
    vectors++;
    assert (pulses === 1) else begin
      miscompares++;
      $error("FAIL held_pulses got %0d want 1", pulses);
    end

    // Judgement coinciding with Step
    load_top();
    press("judge_step_hit", 1'b1);
    repeat (3) do_step(1'b1, 1'b0, "");
    press("judge_step_wrong", 1'b1);

    // Clear, then saturate score and combo
    clr = 1'b1;
    m_light = '0;
    m_score = 0;
    m_combo = 0;
    push_exp("clear", 0, 1'b0);
    tick();
    clr = 1'b0;
    check_out();
    for (int n = 0; n < 260; n++) begin
      load_top();
      press("sat_hit", 1'b0);
    end

    // Reset during JUDGE
    load_top();
    key = 1'b1;
    tick();
    key = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_light = '0;
    m_score = 0;
    m_combo = 0;
    push_exp("reset_mid_judge", 0, 1'b0);
    check_out();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp("post_reset", 0, 1'b0);
      tick();
      check_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lane_column.md
# lane_column

Parametrised DDR lane column: a DEPTH-cell light shift register plus key-press judge, running score and combo counter for one arrow lane. It replaces per-cell light instances with one block that moves notes up the lane on a game tick, judges key presses against the top two cells, and reports per-event signed point deltas. One instance per lane; the top level sums lane deltas and drives the LEDs from `lighton`.

## Interface
Parameters:
- DEPTH, 5: number of light cells; cell 0 is the bottom, cell DEPTH-1 is the top (hit cell). DEPTH must be at least 2.
- PT_W, 4: width of the signed per-event delta `pt`.
- SCORE_W, 10: width of the signed running score.
- COMBO_W, 6: width of the combo counter.
- HIT_PTS, 2: points for a press that lands on the top cell.
- EARLY_PTS, 1: points for a press that lands on cell DEPTH-2.
- MISS_PTS, 2: penalty magnitude when a note leaves the top cell unhit.
- WRONG_PTS, 1: penalty magnitude for a press with no note in the top two cells.

Ports:
- Clock, in, 1: single clock; all state changes on the rising edge.
- Reset, in, 1: asynchronous, active-low reset.
- Enable, in, 1: game running. When low, Step, Spawn and Key are ignored and all state is held.
- Clear, in, 1: synchronous clear of lights, score, combo and key FSM. Takes priority over everything except Reset.
- Step, in, 1: one-cycle game tick that shifts the column up.
- Spawn, in, 1: sampled with Step; the value loaded into cell 0.
- Key, in, 1: lane key level, already synchronised.
- lighton, out, DEPTH: cell lit flags.
- pt, out, PT_W signed: point delta for this cycle.
- pt_valid, out, 1: one-cycle strobe, high when `pt` carries an event.
- score, out, SCORE_W signed: saturating running total.
- combo, out, COMBO_W: consecutive successful hits.

## Operation
- **Reset values:**
  - `lighton`, `pt`, `pt_valid`, `score` and `combo` are all 0.
  - Key FSM starts in UP.
- **Key FSM states:** UP, JUDGE, HELD.
  - UP goes to JUDGE when Key=1 and Enable=1.
  - JUDGE always lasts exactly one cycle. It goes to HELD if Key=1, otherwise to UP.
  - HELD goes to UP when Key=0.
  - Holding the key therefore produces exactly one judgement.
- **Judgement in the JUDGE cycle**, evaluated on the lights before any shift:
  - Top cell lit: it is cleared and the result is a hit, +HIT_PTS.
  - Otherwise, cell DEPTH-2 lit: it is cleared and the result is an early hit, +EARLY_PTS.
  - Otherwise: wrong press, −WRONG_PTS.
- **Step** (when Enable=1):
  - Cell i takes cell i−1, and cell 0 takes Spawn.
  - If the top cell is lit and was not cleared by a judgement in the same cycle, the note is a miss, −MISS_PTS.
- **Judgement and Step in the same cycle:**
  - The judgement clear is applied first, then the shift.
  - `pt` is the sum of both contributions; for example, a wrong press plus a miss gives −3 with the defaults.
- **pt_valid:** high iff at least one event occurred in the cycle.
- **Score:** score + pt, saturated to [−2^(SCORE_W−1), 2^(SCORE_W−1)−1].
- **Combo:**
  - Increments on a hit or early hit, saturating at all-ones.
  - A miss or wrong press in the cycle resets it to 0. Reset takes priority over increment.

## Timing
- **Key press latency:**
  - Key is sampled high at edge k; the FSM is in JUDGE after edge k+1.
  - `pt`, `pt_valid`, `score`, `combo` and the cleared light are all visible after edge k+2.
- **Step latency:** Step is high at edge k; the shifted `lighton` and any miss `pt`/`pt_valid` are visible after edge k+1.
- **Register outputs:** `pt` and `pt_valid` are registered; `pt` returns to 0 whenever `pt_valid` is 0.
- **Reset mid-operation:** Reset asserted during JUDGE aborts the judgement, with no `pt` issued.
- **Clear:** a Clear coinciding with JUDGE or Step suppresses both events.
- **Enable low during JUDGE:** the FSM still completes the transition, but no judgement is applied.

## Structure
- **Package `ddr_pkg`:**
  - Key FSM state enum (UP, JUDGE, HELD).
  - Event encoding (NONE, HIT, EARLY, MISS, WRONG).
  - A saturating-add helper function.
- **Sub-module `lane_key_fsm`:**
  - Inputs: Clock, Reset, Enable, Clear, Key.
  - Output: `judge`, a one-cycle pulse asserted in the JUDGE state.
- **In `lane_column`:** the shift register, judge/miss logic, delta sum, score and combo registers.

## Test plan
1. **Spawn and walk to miss:** Spawn=1 on one Step, then 4 more Steps with DEPTH=5. `lighton` walks 00001, 00010, …, 10000. On the 5th Step, pt=−2 and pt_valid=1; score=−2, combo=0.
2. **Hit:** note in cell 4, then Key pulse. Two cycles after Key, pt=+2, lighton=0, score=+2, combo=1.
3. **Early hit and wrong press:**
   - Note in cell 3, Key pulse: pt=+1, cell 3 cleared.
   - Empty lane, Key pulse: pt=−1, combo reset to 0.
4. **Held key, one judgement:** Key held high for 10 cycles over a note in cell 4. Exactly one pt_valid pulse occurs.
5. **Simultaneous judgement and Step:**
   - JUDGE coincides with Step, note in cell 4: +2 only, no miss.
   - JUDGE coincides with Step, notes only in cells 0–2: pt=−1, no shift loss.
6. **Saturation and reset:**
   - Repeated hits drive score to +511 and it holds there.
   - Reset asserted mid-JUDGE clears all outputs immediately, and no pt_valid follows.
